// File: rtl/mem_bus_responder.sv
// Memory-backed bus responder: answers BusRd/BusRdX from a 256x8 memory after LATENCY
// edges, acknowledges BusUpgr, and accepts cache write-backs in every state.
typedef enum logic [1:0] {
  NO_OP    = 2'b00,
  BUS_RD   = 2'b01,
  BUS_RDX  = 2'b10,
  BUS_UPGR = 2'b11
} bus_request;

module mem_bus_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  bus_request bus_cmd,
  input  logic [7:0] bus_addr,
  input  logic       wb_valid,
  input  logic [7:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic       resp_valid,
  output bus_request resp_cmd,
  output logic [7:0] resp_addr,
  output logic [7:0] resp_data,
  output logic       upgr_ack,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  state_t     state_r;
  logic [3:0] count_r;
  bus_request lat_cmd_r;
  logic [7:0] lat_addr_r;
  logic [7:0] mem_r [256];

  logic       is_read_s;
  logic       bypass_s;
  logic [7:0] rd_data_s;

  // Command decode and read path with write-back forwarding on the response edge
  always_comb begin
    is_read_s = (bus_cmd == BUS_RD) || (bus_cmd == BUS_RDX);
    bypass_s  = wb_valid && (wb_addr == lat_addr_r);
    if (bypass_s) begin
      rd_data_s = wb_data;
    end else begin
      rd_data_s = mem_r[lat_addr_r];
    end
  end

  // Backing memory: identity contents after reset, write-backs land in any state
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_r[i] <= 8'(i);
      end
    end else if (wb_valid) begin
      mem_r[wb_addr] <= wb_data;
    end
  end

  // Transaction FSM with registered response, acknowledge and drop counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      count_r    <= 4'd0;
      lat_cmd_r  <= NO_OP;
      lat_addr_r <= 8'd0;
      resp_valid <= 1'b0;
      resp_cmd   <= NO_OP;
      resp_addr  <= 8'd0;
      resp_data  <= 8'd0;
      upgr_ack   <= 1'b0;
      busy       <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      resp_valid <= 1'b0;
      upgr_ack   <= 1'b0;
      case (state_r)
        // RESP lasts one edge, so every RESP edge is the exit edge and behaves like IDLE
        IDLE, RESP: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          if (is_read_s) begin
            lat_cmd_r  <= bus_cmd;
            lat_addr_r <= bus_addr;
            count_r    <= LOAD;
            state_r    <= WAIT;
            busy       <= 1'b1;
          end else if (bus_cmd == BUS_UPGR) begin
            upgr_ack <= 1'b1;
          end
        end
        WAIT: begin
          if ((bus_cmd != NO_OP) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
          if (count_r == 4'd0) begin
            state_r    <= RESP;
            resp_valid <= 1'b1;
            resp_cmd   <= lat_cmd_r;
            resp_addr  <= lat_addr_r;
            resp_data  <= rd_data_s;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed vector table, corner sequences,
// and randomized traffic against a cycle-indexed transaction model.
module tb_mem_bus_responder;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  bus_request bus_cmd;
  logic [7:0] bus_addr;
  logic       wb_valid;
  logic [7:0] wb_addr;
  logic [7:0] wb_data;

  logic       resp_valid,  resp_valid1;
  bus_request resp_cmd,    resp_cmd1;
  logic [7:0] resp_addr,   resp_addr1;
  logic [7:0] resp_data,   resp_data1;
  logic       upgr_ack,    upgr_ack1;
  logic       busy,        busy1;
  logic [7:0] drop_cnt,    drop_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .resp_valid(resp_valid), .resp_cmd(resp_cmd), .resp_addr(resp_addr),
    .resp_data(resp_data), .upgr_ack(upgr_ack), .busy(busy), .drop_cnt(drop_cnt)
  );

  mem_bus_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .resp_valid(resp_valid1), .resp_cmd(resp_cmd1), .resp_addr(resp_addr1),
    .resp_data(resp_data1), .upgr_ack(upgr_ack1), .busy(busy1), .drop_cnt(drop_cnt1)
  );

  // Reference model: an outstanding read is described by the edge numbers at which it
  // responds and at which the responder becomes free again.
  int         cyc = 0;
  logic [7:0] m_mem [256];
  bit         m_pend;
  int         m_due, m_exit;
  logic [1:0] m_pcmd;
  logic [7:0] m_paddr;
  logic       m_rv, m_upgr;
  logic [1:0] m_cmd;
  logic [7:0] m_addr, m_data, m_drop;

  task automatic model_edge();
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'(i);
      m_pend = 0; m_rv = 1'b0; m_upgr = 1'b0;
      m_cmd = 2'd0; m_addr = 8'd0; m_data = 8'd0; m_drop = 8'd0;
    end else begin
      m_rv = 1'b0; m_upgr = 1'b0;
      if (m_pend && cyc == m_exit) m_pend = 0;
      if (m_pend) begin
        if (bus_cmd != NO_OP && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        if (cyc == m_due) begin
          m_rv = 1'b1; m_cmd = m_pcmd; m_addr = m_paddr;
          m_data = (wb_valid && wb_addr == m_paddr) ? wb_data : m_mem[m_paddr];
        end
      end else if (bus_cmd == BUS_RD || bus_cmd == BUS_RDX) begin
        m_pend = 1; m_due = cyc + LAT; m_exit = cyc + LAT + 1;
        m_pcmd = bus_cmd; m_paddr = bus_addr;
      end else if (bus_cmd == BUS_UPGR) begin
        m_upgr = 1'b1;
      end
      if (wb_valid) m_mem[wb_addr] = wb_data;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(logic r, logic [1:0] c, logic [7:0] a, logic wv, logic [7:0] wa, logic [7:0] wd);
    rst = r; bus_cmd = bus_request'(c); bus_addr = a;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
  endtask

  task automatic compare_model(string tag);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'(m_rv));
    chk({tag, " busy"},       32'(busy),       32'(m_pend));
    chk({tag, " upgr_ack"},   32'(upgr_ack),   32'(m_upgr));
    chk({tag, " drop_cnt"},   32'(drop_cnt),   32'(m_drop));
    chk({tag, " resp_cmd"},   32'(resp_cmd),   32'(m_cmd));
    chk({tag, " resp_addr"},  32'(resp_addr),  32'(m_addr));
    chk({tag, " resp_data"},  32'(resp_data),  32'(m_data));
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] cmd;
    logic [7:0] addr;
    logic       wbv;
    logic [7:0] wba;
    logic [7:0] wbd;
    logic       rv;
    logic [1:0] rcmd;
    logic [7:0] raddr;
    logic [7:0] rdata;
    logic       busy;
    logic       upgr;
    logic [7:0] drop;
  } vec_t;

  vec_t vq[$];

  task automatic add(logic r, logic [1:0] c, logic [7:0] a, logic wv, logic [7:0] wa, logic [7:0] wd,
                     logic rv, logic [1:0] rc, logic [7:0] ra, logic [7:0] rd,
                     logic bz, logic up, logic [7:0] dr);
    vec_t v;
    v = '{r, c, a, wv, wa, wd, rv, rc, ra, rd, bz, up, dr};
    vq.push_back(v);
  endtask

  initial begin
    drive(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 8'h00);

    // reset; commands and write-backs during reset are ignored
    add(0, 0, 8'h00, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 0, 0, 8'd0);
    add(0, 1, 8'h3C, 1, 8'h3C, 8'h77,  0, 0, 8'h00, 8'h00, 0, 0, 8'd0);
    // BusRd 3C, response exactly at E0+3
    add(1, 1, 8'h3C, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  1, 1, 8'h3C, 8'h3C, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h3C, 8'h3C, 0, 0, 8'd0);
    // BusRdX 10 with write-back during WAIT, then BusRd 10 at the exit edge
    add(1, 2, 8'h10, 0, 8'h00, 8'h00,  0, 1, 8'h3C, 8'h3C, 1, 0, 8'd0);
    add(1, 0, 8'h00, 1, 8'h10, 8'hA5,  0, 1, 8'h3C, 8'h3C, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h3C, 8'h3C, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  1, 2, 8'h10, 8'hA5, 1, 0, 8'd0);
    add(1, 1, 8'h10, 0, 8'h00, 8'h00,  0, 2, 8'h10, 8'hA5, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 2, 8'h10, 8'hA5, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 2, 8'h10, 8'hA5, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  1, 1, 8'h10, 8'hA5, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h10, 8'hA5, 0, 0, 8'd0);
    // BusRd 20, two drops, BusRd 30 accepted at E0+4
    add(1, 1, 8'h20, 0, 8'h00, 8'h00,  0, 1, 8'h10, 8'hA5, 1, 0, 8'd0);
    add(1, 1, 8'h21, 0, 8'h00, 8'h00,  0, 1, 8'h10, 8'hA5, 1, 0, 8'd1);
    add(1, 1, 8'h21, 0, 8'h00, 8'h00,  0, 1, 8'h10, 8'hA5, 1, 0, 8'd2);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  1, 1, 8'h20, 8'h20, 1, 0, 8'd2);
    add(1, 1, 8'h30, 0, 8'h00, 8'h00,  0, 1, 8'h20, 8'h20, 1, 0, 8'd2);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h20, 8'h20, 1, 0, 8'd2);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h20, 8'h20, 1, 0, 8'd2);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  1, 1, 8'h30, 8'h30, 1, 0, 8'd2);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h30, 8'h30, 0, 0, 8'd2);
    // BusUpgr: one-cycle ack, nothing else moves
    add(1, 3, 8'h05, 0, 8'h00, 8'h00,  0, 1, 8'h30, 8'h30, 0, 1, 8'd2);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h30, 8'h30, 0, 0, 8'd2);
    // reset aborts a pending read and restores memory
    add(1, 1, 8'h10, 0, 8'h00, 8'h00,  0, 1, 8'h30, 8'h30, 1, 0, 8'd2);
    add(0, 0, 8'h00, 1, 8'h10, 8'hFF,  0, 0, 8'h00, 8'h00, 0, 0, 8'd0);
    for (int k = 0; k < 4; k++)
      add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 0, 0, 8'd0);
    add(1, 1, 8'h10, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 0, 8'h00, 8'h00, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  1, 1, 8'h10, 8'h10, 1, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00,  0, 1, 8'h10, 8'h10, 0, 0, 8'd0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].cmd, vq[i].addr, vq[i].wbv, vq[i].wba, vq[i].wbd);
      tick();
      chk($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'(vq[i].rv));
      chk($sformatf("vec%0d resp_cmd", i),   32'(resp_cmd),   32'(vq[i].rcmd));
      chk($sformatf("vec%0d resp_addr", i),  32'(resp_addr),  32'(vq[i].raddr));
      chk($sformatf("vec%0d resp_data", i),  32'(resp_data),  32'(vq[i].rdata));
      chk($sformatf("vec%0d busy", i),       32'(busy),       32'(vq[i].busy));
      chk($sformatf("vec%0d upgr_ack", i),   32'(upgr_ack),   32'(vq[i].upgr));
      chk($sformatf("vec%0d drop_cnt", i),   32'(drop_cnt),   32'(vq[i].drop));
    end

    // LATENCY=1 instance: respond on the first WAIT edge, idle one edge later
    drive(1'b1, 2'd1, 8'h44, 1'b0, 8'h00, 8'h00);
    tick();
    chk("lat1 accept busy", 32'(busy1), 32'd1);
    chk("lat1 accept resp_valid", 32'(resp_valid1), 32'd0);
    drive(1'b1, 2'd0, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    chk("lat1 resp_valid", 32'(resp_valid1), 32'd1);
    chk("lat1 resp_addr", 32'(resp_addr1), 32'h44);
    chk("lat1 resp_data", 32'(resp_data1), 32'h44);
    chk("lat1 resp_cmd", 32'(resp_cmd1), 32'd1);
    tick();
    chk("lat1 idle resp_valid", 32'(resp_valid1), 32'd0);
    chk("lat1 idle busy", 32'(busy1), 32'd0);

    // drop counter saturation under a continuous stream of reads
    drive(1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    for (int k = 0; k < 420; k++) begin
      drive(1'b1, 2'd1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 8'h00);
      tick();
      compare_model("stress");
    end
    chk("stress drop_cnt saturated", 32'(drop_cnt), 32'hFF);

    // randomized traffic on a narrow address window to provoke forwarding
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 49) != 0),
            2'($urandom_range(0, 3)),
            8'h40 + 8'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0),
            8'h40 + 8'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)));
      tick();
      compare_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL provide parameter LATENCY, default 3, meaning the number of clock edges from command acceptance to the response edge; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port bus_cmd  input  bus_request (2)  arbitrated bus command from the shared bus: No_OP=00, BusRd=01, BusRdX=10, BusUpgr=11.
REQ-005 SHALL have port bus_addr  input  8  address accompanying bus_cmd.
REQ-006 SHALL have port wb_valid  input  1  cache write-back or flush of a Modified line.
REQ-007 SHALL have port wb_addr  input  8  write-back address.
REQ-008 SHALL have port wb_data  input  8  write-back data.
REQ-009 SHALL have port resp_valid  output  1  one-cycle pulse; response data valid.
REQ-010 SHALL have port resp_cmd  output  bus_request (2)  command being answered.
REQ-011 SHALL have port resp_addr  output  8  address being answered.
REQ-012 SHALL have port resp_data  output  8  memory byte for resp_addr.
REQ-013 SHALL have port upgr_ack  output  1  one-cycle acknowledge of BusUpgr.
REQ-014 SHALL have port busy  output  1  a read transaction is outstanding.
REQ-015 SHALL have port drop_cnt  output  8  count of commands ignored while busy.

Function
REQ-016 SHALL hold a 256x8 memory array, fully addressed by 8-bit addresses.
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP, with all outputs registered.
REQ-018 In IDLE, at an edge where bus_cmd is BusRd or BusRdX (acceptance edge E0), the block SHALL latch the command and address, load the counter with LATENCY-1, enter WAIT, and set busy=1.
REQ-019 In WAIT, the counter SHALL decrement each edge; at the edge where the counter equals 0 (edge E0+LATENCY), the block SHALL enter RESP and register resp_valid=1, resp_cmd, resp_addr and resp_data.
REQ-020 At the edge leaving RESP (E0+LATENCY+1), the block SHALL return to IDLE with resp_valid=0 and busy=0; the next command can be accepted at that same edge.
REQ-021 resp_data SHALL equal mem[latched addr] sampled at the response edge.
REQ-022 If wb_valid is asserted with wb_addr equal to the latched address at the response edge, resp_data SHALL equal wb_data (bypass).
REQ-023 wb_valid SHALL write mem[wb_addr]=wb_data at the edge in any FSM state, independent of command handling.
REQ-024 A write-back during WAIT to the latched address SHALL be reflected in resp_data.
REQ-025 BusUpgr in IDLE SHALL pulse upgr_ack for exactly one cycle at the next edge, with no memory access and no state change.
REQ-026 No_OP SHALL never change state.
REQ-027 Any non-No_OP command sampled while the state is WAIT or RESP SHALL be ignored, except at the RESP-exit edge per REQ-020, and SHALL increment drop_cnt.
REQ-028 drop_cnt SHALL saturate at 8'hFF.
REQ-029 resp_addr, resp_cmd and resp_data SHALL hold their last values when resp_valid=0.
REQ-030 With LATENCY=1, the block SHALL go from WAIT to RESP on the first WAIT edge, giving a total of 2 edges from acceptance to IDLE.

Reset
REQ-031 While rst=0 at an edge, the block SHALL set: state=IDLE, counter=0, busy=0, resp_valid=0, upgr_ack=0, resp_cmd=No_OP, resp_addr=0, resp_data=0, drop_cnt=0, and mem[i]=i for all i.
REQ-032 While rst=0, the block SHALL ignore bus_cmd and wb_valid.
REQ-033 A reset during WAIT or RESP SHALL abort the transaction so that no resp_valid pulse is ever produced for it.

Verification
REQ-034 Test: after reset, BusRd to addr 8'h3C at E0 (LATENCY=3) -> resp_valid=1 only at E0+3, with resp_addr=8'h3C, resp_data=8'h3C, resp_cmd=BusRd; busy=0 after E0+4.
REQ-035 Test: BusRdX to 8'h10, then wb_valid with addr 8'h10 and data 8'hA5 one edge later -> resp_data=8'hA5, resp_cmd=BusRdX; a subsequent BusRd to 8'h10 also returns 8'hA5.
REQ-036 Test: BusRd to 8'h20 followed by BusRd to 8'h21 at E0+1 and E0+2 -> only 8'h20 is answered; drop_cnt=2; a BusRd presented at E0+4 is accepted.
REQ-037 Test: BusUpgr to 8'h05 in IDLE -> upgr_ack high for one cycle; busy, resp_valid and drop_cnt stay 0.
REQ-038 Test: BusRd accepted, then rst=0 at E0+1 -> no resp_valid; busy=0; mem[8'h10]=8'h10 even if previously written.
REQ-039 Test: drop_cnt stress with 300 dropped commands -> drop_cnt=8'hFF.
